// File: rtl/bp_pkg.sv
// Shared definitions for the back-propagation stream sequencer.
// Layer codes, FSM states and elaboration-time helpers.
package bp_pkg;

    localparam logic [1:0] LAYER_OUT = 2'b11;
    localparam logic [1:0] LAYER_H2  = 2'b10;
    localparam logic [1:0] LAYER_H1  = 2'b01;
    localparam logic [1:0] LAYER_IN  = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_WAIT_W,
        S_W_OUT,
        S_W_HID,
        S_WAIT_D
    } bp_state_t;

    function automatic int bp_clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bp_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bp_transpose_addr_gen.sv
// Column-major walk over a row-major weight block: addr = BASE + k*(NS+1) + j.
// The bias column NS is skipped; only adders are used.
module bp_transpose_addr_gen #(
    parameter int AW = 8,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_advance,
    input  logic [AW-1:0] i_base,
    input  logic [CW-1:0] i_nd,
    input  logic [CW-1:0] i_ns,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);

    logic [CW-1:0] r_k;
    logic [CW-1:0] r_j;
    logic [AW-1:0] r_col;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_stride;
    logic          w_row_end;

    assign w_stride  = AW'(i_ns) + AW'(1);
    assign w_row_end = (r_k == i_nd - CW'(1));
    assign o_last    = w_row_end && (r_j == i_ns - CW'(1));
    assign o_addr    = r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_j    <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_start) begin
            r_k    <= '0;
            r_j    <= '0;
            r_col  <= i_base;
            r_addr <= i_base;
        end else if (i_advance) begin
            if (w_row_end) begin
                r_k    <= '0;
                r_j    <= r_j + CW'(1);
                r_col  <= r_col + AW'(1);
                r_addr <= r_col + AW'(1);
            end else begin
                r_k    <= r_k + CW'(1);
                r_addr <= r_addr + w_stride;
            end
        end
    end

endmodule

// File: rtl/bp_stream_sequencer.sv
// Feeds node/expected values and transposed weight columns into back_propagation
// and collects the returned deltas into the delta RAM.
module bp_stream_sequencer
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int NODE_ADDR_WIDTH = bp_clog2_min1(NUMBER_OF_OUTPUT_NODE
        + NUMBER_OF_HIDDEN_NODE_LAYER_2 + NUMBER_OF_HIDDEN_NODE_LAYER_1),
    parameter int WEIGHT_ADDR_WIDTH = bp_clog2_min1(
        NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1)
        + NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1)),
    parameter int DELTA_ADDR_WIDTH = bp_clog2_min1(bp_max3(NUMBER_OF_OUTPUT_NODE,
        NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_HIDDEN_NODE_LAYER_1))
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [NODE_ADDR_WIDTH-1:0]   o_node_addr,
    output logic                         o_node_rd,
    input  logic [DATA_WIDTH-1:0]        i_node_rdata,
    input  logic [DATA_WIDTH-1:0]        i_expected_rdata,
    output logic [WEIGHT_ADDR_WIDTH-1:0] o_weight_addr,
    output logic                         o_weight_rd,
    input  logic [DATA_WIDTH-1:0]        i_weight_rdata,
    output logic                         o_data_valid,
    output logic [DATA_WIDTH-1:0]        o_data_node,
    output logic [DATA_WIDTH-1:0]        o_data_expected,
    output logic                         o_weight_valid,
    output logic [DATA_WIDTH-1:0]        o_weight,
    input  logic [LAYER_WIDTH-1:0]       i_current_layer,
    input  logic                         i_weight_req,
    input  logic                         i_delta_valid,
    input  logic [DELTA_ADDR_WIDTH-1:0]  i_delta_addr,
    input  logic [DATA_WIDTH-1:0]        i_delta,
    output logic                         o_delta_we,
    output logic [LAYER_WIDTH-1:0]       o_delta_layer,
    output logic [DELTA_ADDR_WIDTH-1:0]  o_delta_waddr,
    output logic [DATA_WIDTH-1:0]        o_delta_wdata
);

    localparam int DW    = DATA_WIDTH;
    localparam int LW    = LAYER_WIDTH;
    localparam int NAW   = NODE_ADDR_WIDTH;
    localparam int WAW   = WEIGHT_ADDR_WIDTH;
    localparam int DAW   = DELTA_ADDR_WIDTH;
    localparam int NO    = NUMBER_OF_OUTPUT_NODE;
    localparam int NH2   = NUMBER_OF_HIDDEN_NODE_LAYER_2;
    localparam int NH1   = NUMBER_OF_HIDDEN_NODE_LAYER_1;
    localparam int NNODE = NO + NH2 + NH1;
    localparam int CW    = DAW + 1;
    localparam int DCW   = bp_clog2_min1(NNODE + 1);
    localparam int HBASE = NO * (NH2 + 1);

    bp_state_t r_state;
    bp_state_t w_next;

    logic [NAW-1:0] r_node_cnt;
    logic [DCW-1:0] r_dcnt;
    logic           r_pend;
    logic [LW-1:0]  r_pend_layer;
    logic           r_out_done;
    logic           r_hid_done;
    logic           r_node_rd_d1;
    logic           r_exp_d1;
    logic           r_wrd_d1;
    logic           r_data_valid;
    logic [DW-1:0]  r_data_node;
    logic [DW-1:0]  r_data_exp;
    logic           r_weight_valid;
    logic [DW-1:0]  r_weight;
    logic           r_delta_we;
    logic [LW-1:0]  r_delta_layer;
    logic [DAW-1:0] r_delta_waddr;
    logic [DW-1:0]  r_delta_wdata;
    logic           r_done;

    logic           w_node_last;
    logic           w_req_out;
    logic           w_req_hid;
    logic           w_req_new;
    logic           w_direct;
    logic           w_take;
    logic           w_take_hid;
    logic           w_sel_hid;
    logic           w_weight_rd;
    logic           w_all_deltas;
    logic           w_finish;
    logic           w_delta_acc;
    logic [LW-1:0]  w_tag;
    logic [WAW-1:0] w_gen_base;
    logic [CW-1:0]  w_gen_nd;
    logic [CW-1:0]  w_gen_ns;
    logic [WAW-1:0] w_gen_addr;
    logic           w_gen_last;

    assign w_node_last = (r_node_cnt == NAW'(NNODE - 1));

    // A request is dropped if its burst is done, running, or already pending.
    assign w_req_out = i_weight_req && (i_current_layer == LW'(LAYER_H2))
        && !r_out_done && (r_state != S_W_OUT)
        && !(r_pend && (r_pend_layer == LW'(LAYER_H2)));
    assign w_req_hid = i_weight_req && (i_current_layer == LW'(LAYER_H1))
        && !r_hid_done && (r_state != S_W_HID)
        && !(r_pend && (r_pend_layer == LW'(LAYER_H1)));
    assign w_req_new = w_req_out || w_req_hid;

    assign w_direct   = (r_state == S_WAIT_W) && !r_pend;
    assign w_take     = (r_state == S_WAIT_W) && (r_pend || w_req_new);
    assign w_take_hid = r_pend ? (r_pend_layer == LW'(LAYER_H1)) : w_req_hid;
    assign w_sel_hid  = (r_state == S_W_HID)
        || ((r_state == S_WAIT_W) && w_take_hid);

    assign w_weight_rd = (r_state == S_W_OUT) || (r_state == S_W_HID);
    assign w_gen_base  = w_sel_hid ? WAW'(HBASE) : '0;
    assign w_gen_nd    = w_sel_hid ? CW'(NH2) : CW'(NO);
    assign w_gen_ns    = w_sel_hid ? CW'(NH1) : CW'(NH2);

    assign w_all_deltas = (r_dcnt == DCW'(NNODE));
    assign w_finish     = (r_state == S_WAIT_D) && w_all_deltas;
    assign w_delta_acc  = i_delta_valid && (r_state != S_IDLE);

    assign w_tag = (r_dcnt < DCW'(NO))       ? LW'(LAYER_OUT) :
                   (r_dcnt < DCW'(NO + NH2)) ? LW'(LAYER_H2)  :
                                               LW'(LAYER_H1);

    bp_transpose_addr_gen #(
        .AW (WAW),
        .CW (CW)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_take),
        .i_advance (w_weight_rd),
        .i_base    (w_gen_base),
        .i_nd      (w_gen_nd),
        .i_ns      (w_gen_ns),
        .o_addr    (w_gen_addr),
        .o_last    (w_gen_last)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (i_start) w_next = S_DATA;
            S_DATA:   if (w_node_last) w_next = S_WAIT_W;
            S_WAIT_W: if (w_take) w_next = w_take_hid ? S_W_HID : S_W_OUT;
            S_W_OUT:  if (w_gen_last) w_next = r_hid_done ? S_WAIT_D : S_WAIT_W;
            S_W_HID:  if (w_gen_last) w_next = r_out_done ? S_WAIT_D : S_WAIT_W;
            S_WAIT_D: if (w_all_deltas) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_node_cnt   <= '0;
            r_dcnt       <= '0;
            r_pend       <= 1'b0;
            r_pend_layer <= '0;
            r_out_done   <= 1'b0;
            r_hid_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DATA)
                r_node_cnt <= w_node_last ? '0 : r_node_cnt + NAW'(1);
            if (w_finish || (r_state == S_IDLE)) begin
                r_pend <= 1'b0;
            end else if (w_req_new && !w_direct) begin
                r_pend       <= 1'b1;
                r_pend_layer <= i_current_layer;
            end else if ((r_state == S_WAIT_W) && r_pend) begin
                r_pend <= 1'b0;
            end
            if (w_finish) begin
                r_out_done <= 1'b0;
                r_hid_done <= 1'b0;
            end else if (w_gen_last) begin
                if (r_state == S_W_OUT) r_out_done <= 1'b1;
                if (r_state == S_W_HID) r_hid_done <= 1'b1;
            end
            if (w_finish)
                r_dcnt <= '0;
            else if (w_delta_acc)
                r_dcnt <= r_dcnt + DCW'(1);
        end
    end

    // Two-stage output pipe: RAM read latency plus an output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_node_rd_d1   <= 1'b0;
            r_exp_d1       <= 1'b0;
            r_wrd_d1       <= 1'b0;
            r_data_valid   <= 1'b0;
            r_data_node    <= '0;
            r_data_exp     <= '0;
            r_weight_valid <= 1'b0;
            r_weight       <= '0;
            r_delta_we     <= 1'b0;
            r_delta_layer  <= '0;
            r_delta_waddr  <= '0;
            r_delta_wdata  <= '0;
            r_done         <= 1'b0;
        end else begin
            r_node_rd_d1   <= (r_state == S_DATA);
            r_exp_d1       <= (r_state == S_DATA) && (r_node_cnt < NAW'(NO));
            r_wrd_d1       <= w_weight_rd;
            r_data_valid   <= r_node_rd_d1;
            r_data_node    <= r_node_rd_d1 ? i_node_rdata : '0;
            r_data_exp     <= r_exp_d1 ? i_expected_rdata : '0;
            r_weight_valid <= r_wrd_d1;
            r_weight       <= r_wrd_d1 ? i_weight_rdata : '0;
            r_delta_we     <= w_delta_acc;
            if (w_delta_acc) begin
                r_delta_layer <= w_tag;
                r_delta_waddr <= i_delta_addr;
                r_delta_wdata <= i_delta;
            end
            r_done <= w_finish;
        end
    end

    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = r_done;
    assign o_node_rd       = (r_state == S_DATA);
    assign o_node_addr     = r_node_cnt;
    assign o_weight_rd     = w_weight_rd;
    assign o_weight_addr   = w_gen_addr;
    assign o_data_valid    = r_data_valid;
    assign o_data_node     = r_data_node;
    assign o_data_expected = r_data_exp;
    assign o_weight_valid  = r_weight_valid;
    assign o_weight        = r_weight;
    assign o_delta_we      = r_delta_we;
    assign o_delta_layer   = r_delta_layer;
    assign o_delta_waddr   = r_delta_waddr;
    assign o_delta_wdata   = r_delta_wdata;

endmodule

// File: tb/tb_bp_stream_sequencer.sv
// Scoreboard bench for bp_stream_sequencer: a 3/32/32 network plus a 1/1/1 corner.
// Stimulus pushes expectations; negedge monitors pop and compare.
module tb_bp_stream_sequencer;

    localparam int DW  = 32;
    localparam int LW  = 2;
    localparam int NO  = 3;
    localparam int NH2 = 32;
    localparam int NH1 = 32;
    localparam int NN  = NO + NH2 + NH1;
    localparam int NAW = 7;
    localparam int WAW = 11;
    localparam int DAW = 5;
    localparam int HB  = NO * (NH2 + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic           start = 1'b0, busy, done;
    logic [NAW-1:0] node_addr;
    logic           node_rd;
    logic [DW-1:0]  node_rdata = '0, exp_rdata = '0;
    logic [WAW-1:0] weight_addr;
    logic           weight_rd;
    logic [DW-1:0]  weight_rdata = '0;
    logic           data_valid, wvalid, dwe;
    logic [DW-1:0]  data_node, data_exp, wdata, dwdata;
    logic [LW-1:0]  cur_layer = '0, dlayer;
    logic           wreq = 1'b0, dv = 1'b0;
    logic [DAW-1:0] daddr = '0, dwaddr;
    logic [DW-1:0]  d = '0;

    bp_stream_sequencer #(
        .DATA_WIDTH (DW), .LAYER_WIDTH (LW),
        .NUMBER_OF_HIDDEN_NODE_LAYER_1 (NH1),
        .NUMBER_OF_HIDDEN_NODE_LAYER_2 (NH2),
        .NUMBER_OF_OUTPUT_NODE (NO),
        .NODE_ADDR_WIDTH (NAW), .WEIGHT_ADDR_WIDTH (WAW),
        .DELTA_ADDR_WIDTH (DAW)
    ) dut (
        .clk (clk), .rst_n (rst_n), .i_start (start),
        .o_busy (busy), .o_done (done),
        .o_node_addr (node_addr), .o_node_rd (node_rd),
        .i_node_rdata (node_rdata), .i_expected_rdata (exp_rdata),
        .o_weight_addr (weight_addr), .o_weight_rd (weight_rd),
        .i_weight_rdata (weight_rdata),
        .o_data_valid (data_valid), .o_data_node (data_node),
        .o_data_expected (data_exp),
        .o_weight_valid (wvalid), .o_weight (wdata),
        .i_current_layer (cur_layer), .i_weight_req (wreq),
        .i_delta_valid (dv), .i_delta_addr (daddr), .i_delta (d),
        .o_delta_we (dwe), .o_delta_layer (dlayer),
        .o_delta_waddr (dwaddr), .o_delta_wdata (dwdata)
    );

    logic          c_start = 1'b0, c_busy, c_done;
    logic [1:0]    c_node_addr, c_weight_addr;
    logic          c_node_rd, c_weight_rd;
    logic [DW-1:0] c_node_rdata = '0, c_exp_rdata = '0, c_weight_rdata = '0;
    logic          c_data_valid, c_wvalid, c_dwe;
    logic [DW-1:0] c_data_node, c_data_exp, c_wdata, c_dwdata;
    logic [LW-1:0] c_cur_layer = '0, c_dlayer;
    logic          c_wreq = 1'b0, c_dv = 1'b0;
    logic [0:0]    c_daddr = '0, c_dwaddr;
    logic [DW-1:0] c_d = '0;

    bp_stream_sequencer #(
        .DATA_WIDTH (DW), .LAYER_WIDTH (LW),
        .NUMBER_OF_HIDDEN_NODE_LAYER_1 (1),
        .NUMBER_OF_HIDDEN_NODE_LAYER_2 (1),
        .NUMBER_OF_OUTPUT_NODE (1),
        .NODE_ADDR_WIDTH (2), .WEIGHT_ADDR_WIDTH (2),
        .DELTA_ADDR_WIDTH (1)
    ) dut_c (
        .clk (clk), .rst_n (rst_n), .i_start (c_start),
        .o_busy (c_busy), .o_done (c_done),
        .o_node_addr (c_node_addr), .o_node_rd (c_node_rd),
        .i_node_rdata (c_node_rdata), .i_expected_rdata (c_exp_rdata),
        .o_weight_addr (c_weight_addr), .o_weight_rd (c_weight_rd),
        .i_weight_rdata (c_weight_rdata),
        .o_data_valid (c_data_valid), .o_data_node (c_data_node),
        .o_data_expected (c_data_exp),
        .o_weight_valid (c_wvalid), .o_weight (c_wdata),
        .i_current_layer (c_cur_layer), .i_weight_req (c_wreq),
        .i_delta_valid (c_dv), .i_delta_addr (c_daddr), .i_delta (c_d),
        .o_delta_we (c_dwe), .o_delta_layer (c_dlayer),
        .o_delta_waddr (c_dwaddr), .o_delta_wdata (c_dwdata)
    );

    // Sync-read RAM models: node = addr, expected = addr + 0x100, weight = addr.
    always @(posedge clk) begin
        if (node_rd) begin
            node_rdata <= 32'(node_addr);
            exp_rdata  <= 32'(node_addr) + 32'h100;
        end
        if (weight_rd) weight_rdata <= 32'(weight_addr);
        if (c_node_rd) begin
            c_node_rdata <= 32'(c_node_addr);
            c_exp_rdata  <= 32'(c_node_addr) + 32'h100;
        end
        if (c_weight_rd) c_weight_rdata <= 32'(c_weight_addr);
    end

    logic [63:0] q_data[$], cq_data[$];
    logic [31:0] q_w[$], cq_w[$];
    logic [65:0] q_d[$], cq_d[$];

    int n_chk = 0, n_fail = 0;
    int n_wrd = 0, n_dwr = 0, n_done = 0, c_n_done = 0;
    int last_nrd = -1, first_wrd = -1, dwe_last = -1, done_cyc = -1;
    int saw32 = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic extra(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: output beat with no expectation (cycle %0d)", nm, cyc);
    endtask

    always @(negedge clk) begin
        logic [63:0] ed;
        logic [31:0] ew;
        logic [65:0] ee;
        if (node_rd) last_nrd = cyc;
        if (weight_rd) begin
            n_wrd++;
            if (first_wrd < 0) first_wrd = cyc;
            if (weight_addr == 11'd32) saw32 = 1;
        end
        if (data_valid) begin
            if (q_data.size() == 0) extra("data_extra");
            else begin
                ed = q_data.pop_front();
                chk("data_node", data_node, ed[63:32]);
                chk("data_exp", data_exp, ed[31:0]);
            end
        end
        if (wvalid) begin
            if (q_w.size() == 0) extra("weight_extra");
            else begin
                ew = q_w.pop_front();
                chk("weight", wdata, ew);
            end
        end
        if (dwe) begin
            n_dwr++;
            if (n_dwr == NN) dwe_last = cyc;
            if (q_d.size() == 0) extra("delta_extra");
            else begin
                ee = q_d.pop_front();
                chk("delta_layer", 32'(dlayer), 32'(ee[65:64]));
                chk("delta_addr", 32'(dwaddr), ee[63:32]);
                chk("delta_data", dwdata, ee[31:0]);
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        logic [63:0] ed;
        logic [31:0] ew;
        logic [65:0] ee;
        if (c_data_valid) begin
            if (cq_data.size() == 0) extra("c_data_extra");
            else begin
                ed = cq_data.pop_front();
                chk("c_data_node", c_data_node, ed[63:32]);
                chk("c_data_exp", c_data_exp, ed[31:0]);
            end
        end
        if (c_wvalid) begin
            if (cq_w.size() == 0) extra("c_weight_extra");
            else begin
                ew = cq_w.pop_front();
                chk("c_weight", c_wdata, ew);
            end
        end
        if (c_dwe) begin
            if (cq_d.size() == 0) extra("c_delta_extra");
            else begin
                ee = cq_d.pop_front();
                chk("c_delta_layer", 32'(c_dlayer), 32'(ee[65:64]));
                chk("c_delta_addr", 32'(c_dwaddr), ee[63:32]);
                chk("c_delta_data", c_dwdata, ee[31:0]);
            end
        end
        if (c_done) c_n_done++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_data();
        for (int i = 0; i < NN; i++)
            q_data.push_back({32'(i), (i < NO) ? 32'(i) + 32'h100 : 32'h0});
    endtask

    task automatic push_w(input int base, input int nd, input int ns);
        for (int j = 0; j < ns; j++)
            for (int k = 0; k < nd; k++)
                q_w.push_back(32'(base + k * (ns + 1) + j));
    endtask

    task automatic drive_delta(input int i);
        logic [1:0] lyr;
        int idx;
        if (i < NO) begin lyr = 2'b11; idx = i; end
        else if (i < NO + NH2) begin lyr = 2'b10; idx = i - NO; end
        else begin lyr = 2'b01; idx = i - NO - NH2; end
        dv = 1'b1;
        daddr = DAW'(idx);
        d = 32'hD000_0000 + 32'(i);
        q_d.push_back({lyr, 32'(idx), d});
    endtask

    task automatic wait_data_end(input string nm);
        int t = 0;
        while (node_rd && t < 300) begin tick(1); t++; end
        chk(nm, 32'(node_rd), 32'd0);
    endtask

    task automatic wait_burst(input string nm);
        int t = 0;
        while (!weight_rd && t < 50) begin tick(1); t++; end
        t = 0;
        while (weight_rd && t < 2000) begin tick(1); t++; end
        chk(nm, 32'(weight_rd), 32'd0);
    endtask

    task automatic req(input logic [1:0] lyr);
        cur_layer = lyr;
        wreq = 1'b1;
        tick(1);
        wreq = 1'b0;
    endtask

    initial begin
        int nb;
        int t;
        tick(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_node_rd", 32'(node_rd), 0);
        chk("rst_node_addr", 32'(node_addr), 0);
        chk("rst_weight_rd", 32'(weight_rd), 0);
        chk("rst_valids", 32'({data_valid, wvalid, dwe}), 0);
        rst_n = 1'b1;
        tick(2);

        drive_delta(0);
        void'(q_d.pop_back());
        tick(1);
        dv = 1'b0;
        tick(3);
        chk("idle_delta_drop", n_dwr, 0);

        // Sample 1: latched request during DATA, then hidden burst with deltas.
        push_data();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        req(2'b10);
        push_w(0, NO, NH2);
        tick(9);
        req(2'b00);
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_data_end("data1_end");
        wait_burst("wout1_end");
        chk("latch_gap", 32'(first_wrd - last_nrd), 32'd2);
        tick(3);
        chk("data1_drain", 32'(q_data.size()), 0);
        chk("wout1_drain", 32'(q_w.size()), 0);
        chk("addr32_unread", 32'(saw32), 0);

        nb = n_wrd;
        req(2'b00);
        tick(3);
        req(2'b10);
        tick(6);
        chk("ignored_reqs", 32'(n_wrd - nb), 0);

        push_w(HB, NH2, NH1);
        req(2'b01);
        for (int i = 0; i < NN - 1; i++) begin
            drive_delta(i);
            if (i == 30) begin
                cur_layer = 2'b01;
                wreq = 1'b1;
            end
            tick(1);
            wreq = 1'b0;
        end
        dv = 1'b0;
        t = 0;
        while (!(weight_rd && weight_addr == 11'd1153) && t < 1200) begin
            tick(1);
            t++;
        end
        chk("hid_last_addr", 32'(weight_addr), 32'd1153);
        drive_delta(NN - 1);
        tick(1);
        dv = 1'b0;
        t = 0;
        while (n_done == 0 && t < 50) begin tick(1); t++; end
        tick(3);
        chk("done_count", n_done, 1);
        chk("done_lat", 32'(done_cyc - dwe_last), 32'd1);
        chk("busy_idle", 32'(busy), 0);
        chk("hid_beats", 32'(n_wrd - nb), 32'd1024);
        chk("whid_drain", 32'(q_w.size()), 0);
        chk("delta_drain", 32'(q_d.size()), 0);

        // Sample 2: request after DATA, then reset in the middle of W_HID.
        push_data();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_data_end("data2_end");
        push_w(0, NO, NH2);
        req(2'b10);
        wait_burst("wout2_end");
        tick(3);
        chk("wout2_drain", 32'(q_w.size()), 0);
        push_w(HB, NH2, NH1);
        req(2'b01);
        tick(100);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_weight_rd", 32'(weight_rd), 0);
        chk("arst_weight_addr", 32'(weight_addr), 0);
        chk("arst_wvalid", 32'(wvalid), 0);
        chk("arst_weight", wdata, 0);
        q_w.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        push_data();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("replay_rd", 32'(node_rd), 1);
        chk("replay_addr0", 32'(node_addr), 0);
        wait_data_end("data3_end");
        tick(3);
        chk("replay_drain", 32'(q_data.size()), 0);
        chk("abort_no_done", n_done, 1);

        // Corner: one node per layer.
        cq_data.push_back({32'd0, 32'h100});
        cq_data.push_back({32'd1, 32'h0});
        cq_data.push_back({32'd2, 32'h0});
        c_start = 1'b1;
        tick(1);
        c_start = 1'b0;
        tick(5);
        cq_w.push_back(32'd0);
        c_cur_layer = 2'b10;
        c_wreq = 1'b1;
        tick(1);
        c_wreq = 1'b0;
        tick(5);
        cq_w.push_back(32'd2);
        c_cur_layer = 2'b01;
        c_wreq = 1'b1;
        tick(1);
        c_wreq = 1'b0;
        tick(5);
        for (int i = 0; i < 3; i++) begin
            c_dv = 1'b1;
            c_daddr = 1'b0;
            c_d = 32'hC000_0000 + 32'(i);
            cq_d.push_back({(i == 0) ? 2'b11 : (i == 1) ? 2'b10 : 2'b01,
                            32'd0, c_d});
            tick(1);
        end
        c_dv = 1'b0;
        tick(6);
        chk("c_done", c_n_done, 1);
        chk("c_busy", 32'(c_busy), 0);
        chk("c_drain", 32'(cq_data.size() + cq_w.size() + cq_d.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
